// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
`default_nettype none

package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DETECTED = 2'd2
  } dl_state_e;

  // Width able to hold 0..thresh for the persistence counter.
  function automatic int persist_cnt_w(input int thresh);
    return (thresh < 1) ? 1 : $clog2(thresh + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hls_dl_dep_merge.sv
// OR-merge of the valid-masked incoming dependency vectors.
`default_nettype none

module hls_dl_dep_merge #(
  parameter int PROC_NUM    = 4,
  parameter int IN_CHAN_NUM = 2
) (
  input  logic [IN_CHAN_NUM-1:0]          i_chan_vld,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] i_chan_data,
  output logic [PROC_NUM-1:0]             o_dep
);

  always_comb begin
    o_dep = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (i_chan_vld[i]) begin
        o_dep = o_dep | i_chan_data[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor: dependency forwarding, persistence-filtered detection, report-token ring.
// Optional DEADLOCK_TIMESTAMP_EN adds a free-running counter latched into dl_timestamp on detection.
`default_nettype none

module hls_deadlock_monitor_unit
  import hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int PROC_ID       = 0,
  parameter int IN_CHAN_NUM   = 2,
  parameter int OUT_CHAN_NUM  = 3,
  parameter int DETECT_THRESH = 4,
  parameter int CNT_W         = 8
`ifdef DEADLOCK_TIMESTAMP_EN
  ,
  parameter int TS_W          = 32
`endif
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [OUT_CHAN_NUM-1:0]         dl_report_chan_vec,
  output logic [CNT_W-1:0]                dl_event_cnt
`ifdef DEADLOCK_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]                 dl_timestamp
`endif
);

  localparam int                 PW       = persist_cnt_w(DETECT_THRESH);
  localparam logic [PW-1:0]      ARM_LAST = PW'(DETECT_THRESH - 1);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  logic [PROC_NUM-1:0]     dep_comb;
  logic [PROC_NUM-1:0]     dep;
  logic                    dep_open;
  logic                    any_blocked;
  logic                    hit;
  logic                    enter_det;
  logic                    tok_fwd;

  logic [PROC_NUM-1:0]     dep_reg_q, dep_reg_d;
  dl_state_e               state_q, state_d;
  logic [PW-1:0]           cnt_q, cnt_d;
  logic                    detect_q, detect_d;
  logic [OUT_CHAN_NUM-1:0] report_q, report_d;
  logic [CNT_W-1:0]        evt_q, evt_d;
  logic [OUT_CHAN_NUM-1:0] token_q, token_d;

  hls_dl_dep_merge #(
    .PROC_NUM    (PROC_NUM),
    .IN_CHAN_NUM (IN_CHAN_NUM)
  ) u_dep_merge (
    .i_chan_vld  (in_chan_dep_vld_vec),
    .i_chan_data (in_chan_dep_data_vec),
    .o_dep       (dep_comb)
  );

  // Once a deadlock is flagged globally, the channels are frozen unless a report token opens them.
  assign dep_open    = ~dl_detect_in | (|token_in_vec);
  assign dep         = dep_open ? dep_comb : dep_reg_q;
  assign any_blocked = |proc_dep_vld_vec;
  assign hit         = dep_open & dep[PROC_ID] & any_blocked;
  assign tok_fwd     = ((|token_in_vec) & ~token_clear) | origin;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_det = 1'b0;
    if (token_clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (DETECT_THRESH == 1) begin
              state_d   = ST_DETECTED;
              enter_det = 1'b1;
            end else begin
              state_d = ST_ARMED;
              cnt_d   = PW'(1);
            end
          end
        end
        ST_ARMED: begin
          if (!hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ARM_LAST) begin
            state_d   = ST_DETECTED;
            cnt_d     = '0;
            enter_det = 1'b1;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
        ST_DETECTED: ;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dep_reg_d = any_blocked ? dep : '0;
    detect_d  = (state_d == ST_DETECTED);
    report_d  = enter_det ? proc_dep_vld_vec : report_q;
    evt_d     = evt_q;
    if (enter_det && (evt_q != {CNT_W{1'b1}})) begin
      evt_d = evt_q + CNT_W'(1);
    end
    token_d   = tok_fwd ? proc_dep_vld_vec : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dep_reg_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      detect_q  <= 1'b0;
      report_q  <= '0;
      evt_q     <= '0;
      token_q   <= '0;
    end else begin
      dep_reg_q <= dep_reg_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      detect_q  <= detect_d;
      report_q  <= report_d;
      evt_q     <= evt_d;
      token_q   <= token_d;
    end
  end

`ifdef DEADLOCK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ts_lat_q, ts_lat_d;

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    ts_lat_d = enter_det ? ts_q : ts_lat_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q     <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
    end
  end

  assign dl_timestamp = ts_lat_q;
`endif

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg_q | SELF_BIT;
  assign token_out_vec        = token_q;
  assign dl_detect_out        = detect_q;
  assign dl_report_chan_vec   = report_q;
  assign dl_event_cnt         = evt_q;

endmodule

`default_nettype wire
